// File: rtl/flit_pkg.sv
// ---------------------------------------------------------------------------
// flit_pkg
// Shared types and constants for the flit transmitter.
//   CREDIT_MAX  : entries in the output skid buffer (buffered + in-flight cap)
//   FLIT_CNT_W  : width of the optional accepted-flit counter
//   IDX_W       : width of the flit index within a packet
//   flit_hdr_t  : head/tail marking that travels with each flit's data
//   tx_state_e  : reset-hold / run states of the read controller
//   stamp_hdr() : derives head/tail marking from a packet index
// ---------------------------------------------------------------------------
package flit_pkg;

  localparam logic [1:0] CREDIT_MAX = 2'd2;
  localparam int         FLIT_CNT_W = 16;
  localparam int         IDX_W      = 8;

  // Marking for one flit. The data field is sized by the user of this type
  // (FIFO_WIDTH), so it lives alongside this struct in the module that owns it.
  typedef struct packed {
    logic head;
    logic tail;
  } flit_hdr_t;

  typedef enum logic {
    ST_HOLD = 1'b0,  // first cycle(s) out of reset: no reads allowed
    ST_RUN  = 1'b1
  } tx_state_e;

  function automatic flit_hdr_t stamp_hdr(input logic [IDX_W-1:0] idx,
                                          input logic [IDX_W-1:0] last_idx);
    flit_hdr_t hdr;
    hdr.head = (idx == '0);
    hdr.tail = (idx == last_idx);
    return hdr;
  endfunction

endpackage

// File: rtl/flit_skid_buf.sv
// ---------------------------------------------------------------------------
// flit_skid_buf
// Two-entry in-order buffer. Entry 0 is the head and feeds the link outputs
// straight from a register; entry 1 catches the flit that arrives while the
// head is stalled.
//   clk, reset : clock, asynchronous active-high reset
//   push       : write push_data this cycle
//   push_data  : incoming flit data
//   pop        : head entry leaves this cycle
//   head_data  : registered head entry
//   full       : both entries occupied
//   empty      : no entries occupied
// ---------------------------------------------------------------------------
module flit_skid_buf
  import flit_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] ent0, ent1;
  logic             vld0, vld1;

  // NOTE: the data registers are reset too (not just the valid bits) because
  // the head entry drives the link data pins, which must read 0 out of reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ent0 <= '0;
      ent1 <= '0;
      vld0 <= 1'b0;
      vld1 <= 1'b0;
    end else if (push && pop) begin
      // Occupancy is unchanged; the queue just advances by one slot.
      if (vld1) begin
        ent0 <= ent1;
        ent1 <= push_data;
      end else begin
        ent0 <= push_data;
      end
    end else if (pop) begin
      ent0 <= ent1;
      vld0 <= vld1;
      vld1 <= 1'b0;
    end else if (push) begin
      if (!vld0) begin
        ent0 <= push_data;
        vld0 <= 1'b1;
      end else begin
        ent1 <= push_data;
        vld1 <= 1'b1;
      end
    end
  end

  assign head_data = ent0;
  assign full      = vld1;
  assign empty     = !vld0;

  a_pop_not_empty: assert property (@(posedge clk) disable iff (reset) pop |-> vld0);

endmodule

// File: rtl/flit_tx.sv
// ---------------------------------------------------------------------------
// flit_tx
// Pulls flits from an upstream FIFO (one-cycle read latency) and presents
// them on a valid/ready link with head/tail packet marking. A credit count
// (buffered + in-flight reads, max 2) throttles reads so the 2-entry skid
// buffer can never overflow while still streaming one flit per cycle.
//
// Optional feature: define FLIT_TX_STATS_EN to add the o_flit_count port,
// a 16-bit wrapping count of accepted flits.
//
// Ports
//   clk            : clock
//   reset          : asynchronous active-high reset
//   i_rd_valid     : upstream FIFO not empty
//   o_rd_fifoReady : upstream FIFO read enable (one pop per high cycle)
//   i_fifoRdData   : upstream FIFO data, valid the cycle after a read
//   o_tx_valid     : link flit valid
//   o_tx_data      : link flit data
//   o_tx_head      : first flit of a packet
//   o_tx_tail      : last flit of a packet
//   i_tx_ready     : link can accept a flit this cycle
//   o_flit_count   : accepted-flit count (FLIT_TX_STATS_EN only)
// ---------------------------------------------------------------------------
module flit_tx
  import flit_pkg::*;
#(
  parameter int FIFO_WIDTH = 8,
  parameter int PKT_LEN    = 4   // 1..255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_rd_valid,
  output logic                  o_rd_fifoReady,
  input  logic [FIFO_WIDTH-1:0] i_fifoRdData,
  output logic                  o_tx_valid,
  output logic [FIFO_WIDTH-1:0] o_tx_data,
  output logic                  o_tx_head,
  output logic                  o_tx_tail,
  input  logic                  i_tx_ready
`ifdef FLIT_TX_STATS_EN
  ,
  output logic [FLIT_CNT_W-1:0] o_flit_count
`endif
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PKT_LEN - 1);

  tx_state_e        state, state_next;
  logic             run;
  logic             pop, push, rd_en, in_flight;
  logic [1:0]       credit, credit_after_pop, credit_next;
  logic [IDX_W-1:0] idx;
  logic             buf_full, buf_empty;
  flit_hdr_t        hdr;

  // ---------------------------------------------------------------------
  // Reset-hold controller: reads stay gated until one clean clock edge has
  // been seen after reset, so the read enable is 0 throughout reset.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_HOLD;
    else       state <= state_next;
  end

  // NOTE: every signal assigned in a combinational block gets a default at the
  // top, so no path through the case can leave it unassigned and infer a latch.
  always_comb begin
    state_next = state;
    run        = 1'b0;
    case (state)
      ST_HOLD: state_next = ST_RUN;
      ST_RUN:  run        = 1'b1;
      default: state_next = ST_HOLD;
    endcase
  end

  // ---------------------------------------------------------------------
  // Credit / read control. A pop this cycle frees a slot immediately, which
  // is what lets a stalled-then-released link restart reads without a bubble.
  // ---------------------------------------------------------------------
  assign pop  = o_tx_valid & i_tx_ready;
  assign push = in_flight;

  always_comb begin
    credit_after_pop = credit - {1'b0, pop};
    rd_en            = run & i_rd_valid & (credit_after_pop < CREDIT_MAX);
    credit_next      = credit_after_pop + {1'b0, rd_en};
  end

  assign o_rd_fifoReady = rd_en;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      credit    <= '0;
      in_flight <= 1'b0;
      idx       <= '0;
    end else begin
      credit    <= credit_next;
      in_flight <= rd_en;
      if (pop) idx <= (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
    end
  end

  // ---------------------------------------------------------------------
  // Skid buffer: data captured the cycle after the read, written at that edge.
  // ---------------------------------------------------------------------
  flit_skid_buf #(.WIDTH(FIFO_WIDTH)) u_skid (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (i_fifoRdData),
    .pop       (pop),
    .head_data (o_tx_data),
    .full      (buf_full),
    .empty     (buf_empty)
  );

  // Marking comes from the index at the moment the flit sits at the buffer
  // head; the index only moves on a transfer, so stalls leave it untouched.
  assign hdr        = stamp_hdr(idx, LAST_IDX);
  assign o_tx_valid = !buf_empty;
  assign o_tx_head  = o_tx_valid & hdr.head;
  assign o_tx_tail  = o_tx_valid & hdr.tail;

`ifdef FLIT_TX_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)    o_flit_count <= '0;
    else if (pop) o_flit_count <= o_flit_count + FLIT_CNT_W'(1);
  end
`endif

  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
                                  !(push && buf_full && !pop));
  a_credit_range: assert property (@(posedge clk) disable iff (reset)
                                   credit <= CREDIT_MAX);

endmodule
